blackparrot_fpga_host_csr: RTL and testbench
============================================

Name: blackparrot_fpga_host_csr

Overview:
AXI4-Lite slave register file that lets host software (PCIe/Zynq PS master) reach the BlackParrot MMIO host FIFOs. It sits directly downstream of blackparrot_fpga_host_mmio and connects to its mmio request, count and response ports.
- Reads of the request-data CSR pop the BP MMIO request FIFO.
- Writes to the response CSR push the BP MMIO response FIFO.
- Status, error and ID registers give software visibility.

Parameters:
s_axil_addr_width_p, 32, AXI-Lite address width
s_axil_data_width_p, 32, AXI-Lite data width; must be 32
csr_space_width_p, 8, low address bits decoded; higher bits ignored
fifo_data_width_p, 32, FIFO data width; must be 32
id_val_p, 32'hB9A1_0001, constant returned by the ID CSR

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_axil_awaddr  in  s_axil_addr_width_p  write address
s_axil_awvalid / s_axil_awready  in/out  1  AW handshake
s_axil_wdata  in  32  write data
s_axil_wstrb  in  4  ignored; full-word writes only
s_axil_wvalid / s_axil_wready  in/out  1  W handshake
s_axil_bresp  out  2  write response
s_axil_bvalid / s_axil_bready  out/in  1  B handshake
s_axil_araddr  in  s_axil_addr_width_p  read address
s_axil_arvalid / s_axil_arready  in/out  1  AR handshake
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  read response
s_axil_rvalid / s_axil_rready  out/in  1  R handshake
mmio_v_i, mmio_data_i[32], mmio_yumi_o  in,in,out  —  BP request FIFO head
mmio_data_count_v_i, mmio_data_count_i[32], mmio_data_count_yumi_o  in,in,out  —  request count
mmio_v_o, mmio_data_o[32], mmio_ready_and_i  out,out,in  —  BP response FIFO tail

Behaviour:
- Reset: all AXI ready/valid outputs = 0 during reset; bresp, rresp, rdata = 0; mmio_yumi_o, mmio_data_count_yumi_o, mmio_v_o = 0; sticky flags cleared; latched AW/W dropped. The first cycle after reset deasserts: awready = wready = arready = 1.
- CSR map, decoded on addr[csr_space_width_p-1:2] (addr[1:0] ignored):
  - 0x00 REQ_DATA (RO): returns mmio_data_i and pops it. If the FIFO is empty, returns 0, does not pop, and sets sticky underflow.
  - 0x04 REQ_COUNT (RO): returns mmio_data_count_i; pulses mmio_data_count_yumi_o.
  - 0x08 RESP_DATA (WO): pushes wdata. If mmio_ready_and_i = 0 at the push cycle: drop the data, set sticky overflow, bresp = SLVERR (2'b10).
  - 0x0C STATUS: read returns bit0 = mmio_v_i, bit1 = mmio_ready_and_i, bit2 = underflow, bit3 = overflow, others 0. Write is W1C on bits 2 and 3.
  - 0x10 ID (RO): returns id_val_p.
  - Unmapped, reads of WO, writes of RO: rdata = 0, SLVERR, no side effect.
- Read channel (one outstanding):
  - arready = ~rvalid.
  - On the AR handshake at cycle N: decode, register rdata/rresp, assert the pop/count yumi combinationally in cycle N.
  - rvalid rises at N+1 and holds, with stable data, until rready.
  - Pop occurs exactly once per accepted read, regardless of R backpressure.
- Write channel (one outstanding):
  - AW and W are accepted independently into single-entry holding registers; awready = ~aw_held, wready = ~w_held.
  - When both are held and bvalid = 0, the write executes in cycle M: mmio_v_o = 1 combinationally for a RESP_DATA write, W1C applied. bvalid rises at M+1.
  - Holding registers clear at M; bvalid clears on bready.
  - mmio_v_o is asserted only in the execute cycle, never speculatively.
- Simultaneous events:
  - Read and write channels are independent and may execute in the same cycle.
  - Sticky set and W1C clear in the same cycle: set wins.
  - A STATUS read in the same cycle as a flag set returns the pre-set value.
- Reset mid-transaction: outstanding B/R responses are abandoned (master is reset alongside); no FIFO push/pop is issued in the reset cycle.
- OKAY = 2'b00, SLVERR = 2'b10; no other codes.

Decomposition:
- Package blackparrot_fpga_host_csr_pkg:
  - CSR offset localparams: REQ_DATA, REQ_COUNT, RESP_DATA, STATUS, ID.
  - Status bit indices.
  - AXI resp enum.
  - csr_space_width_p default.
- Sub-module blackparrot_fpga_host_csr_aw_w_join: the single-entry AW and W holding registers plus the join handshake, producing v/addr/data/yumi.
- The top level holds decode, read-response register, sticky flags and B logic.

Test Plan:
- Request FIFO holds 0x8000_1000, 0xDEAD_BEEF; count = 2. Read 0x04 → 2. Read 0x00 twice → 0x8000_1000 then 0xDEAD_BEEF; exactly two mmio_yumi_o pulses; rresp OKAY.
- Empty FIFO, read 0x00 → rdata 0, no yumi. STATUS read → 0x4 (bit1 also set if response FIFO ready). Write 0x4 to 0x0C → STATUS bit2 = 0.
- mmio_ready_and_i = 1, write 0x1234_5678 to 0x08 with W presented 3 cycles before AW → one mmio_v_o pulse carrying 0x1234_5678, bvalid one cycle after execute, bresp OKAY.
- mmio_ready_and_i = 0, write to 0x08 → no mmio_v_o, bresp SLVERR, STATUS bit3 = 1.
- Read 0x00 with rready held low 5 cycles → single yumi at AR accept, rdata stable 5 cycles, arready = 0 until R completes.
- Read 0x10 → 0xB9A1_0001. Read 0x20 → 0 with SLVERR. Reset asserted while bvalid is pending → bvalid = 0 next cycle, no extra push.

Source files
------------

// File: rtl/blackparrot_fpga_host_csr_pkg.sv
// CSR offsets, status bit positions, AXI-Lite response codes and the shared
// address decoder for the BlackParrot host CSR block.
package blackparrot_fpga_host_csr_pkg;

  localparam int csr_space_width_gp = 8;

  localparam logic [31:0] csr_req_data_gp   = 32'h00;
  localparam logic [31:0] csr_req_count_gp  = 32'h04;
  localparam logic [31:0] csr_resp_data_gp  = 32'h08;
  localparam logic [31:0] csr_status_gp     = 32'h0C;
  localparam logic [31:0] csr_id_gp         = 32'h10;

  localparam int status_req_v_bit_gp      = 0;
  localparam int status_resp_ready_bit_gp = 1;
  localparam int status_underflow_bit_gp  = 2;
  localparam int status_overflow_bit_gp   = 3;

  typedef enum logic [1:0] {
    axil_resp_okay_e   = 2'b00,
    axil_resp_slverr_e = 2'b10
  } axil_resp_e;

  typedef enum logic [2:0] {
    csr_sel_req_data_e,
    csr_sel_req_count_e,
    csr_sel_resp_data_e,
    csr_sel_status_e,
    csr_sel_id_e,
    csr_sel_none_e
  } csr_sel_e;

  // Offset is already masked to the decoded CSR window; byte lane bits dropped here.
  function automatic csr_sel_e csr_decode(input logic [31:0] offset);
    csr_sel_e sel;
    case (offset & 32'hFFFF_FFFC)
      csr_req_data_gp:  sel = csr_sel_req_data_e;
      csr_req_count_gp: sel = csr_sel_req_count_e;
      csr_resp_data_gp: sel = csr_sel_resp_data_e;
      csr_status_gp:    sel = csr_sel_status_e;
      csr_id_gp:        sel = csr_sel_id_e;
      default:          sel = csr_sel_none_e;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/blackparrot_fpga_host_csr_aw_w_join.sv
// Single-entry AW and W holding registers joined into one write request.
// Each channel accepts independently; a held beat blocks its channel until yumi_i.
module blackparrot_fpga_host_csr_aw_w_join #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic [addr_width_p-1:0] awaddr,
  input  logic                    awvalid,
  output logic                    awready,

  input  logic [data_width_p-1:0] wdata,
  input  logic                    wvalid,
  output logic                    wready,

  output logic                    v_o,
  output logic [addr_width_p-1:0] addr_o,
  output logic [data_width_p-1:0] data_o,
  input  logic                    yumi_i
);

  logic aw_held, w_held;

  assign awready = ~reset & ~aw_held;
  assign wready  = ~reset & ~w_held;
  assign v_o     = aw_held & w_held;

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_held <= 1'b0;
      addr_o  <= '0;
    end else if (yumi_i) begin
      aw_held <= 1'b0;
    end else if (awvalid & awready) begin
      aw_held <= 1'b1;
      addr_o  <= awaddr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_held <= 1'b0;
      data_o <= '0;
    end else if (yumi_i) begin
      w_held <= 1'b0;
    end else if (wvalid & wready) begin
      w_held <= 1'b1;
      data_o <= wdata;
    end
  end

endmodule

// File: rtl/blackparrot_fpga_host_csr.sv
// AXI4-Lite CSR slave bridging host software to the BlackParrot MMIO FIFOs.
// Reads/writes respond one cycle after execute; one outstanding per channel, held until rready/bready.
module blackparrot_fpga_host_csr
  import blackparrot_fpga_host_csr_pkg::*;
#(
  parameter int          s_axil_addr_width_p = 32,
  parameter int          s_axil_data_width_p = 32,
  parameter int          csr_space_width_p   = csr_space_width_gp,
  parameter int          fifo_data_width_p   = 32,
  parameter logic [31:0] id_val_p            = 32'hB9A1_0001
) (
  input  logic                           clk,
  input  logic                           reset,

  input  logic [s_axil_addr_width_p-1:0] s_axil_awaddr,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [s_axil_data_width_p-1:0] s_axil_wdata,
  input  logic [3:0]                     s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,

  input  logic [s_axil_addr_width_p-1:0] s_axil_araddr,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  output logic [s_axil_data_width_p-1:0] s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready,

  input  logic                           mmio_v_i,
  input  logic [fifo_data_width_p-1:0]   mmio_data_i,
  output logic                           mmio_yumi_o,

  input  logic                           mmio_data_count_v_i,
  input  logic [31:0]                    mmio_data_count_i,
  output logic                           mmio_data_count_yumi_o,

  output logic                           mmio_v_o,
  output logic [fifo_data_width_p-1:0]   mmio_data_o,
  input  logic                           mmio_ready_and_i
);

  localparam logic [s_axil_addr_width_p-1:0] csr_mask_lp =
    s_axil_addr_width_p'((64'h1 << csr_space_width_p) - 64'h1);

  wire unused_wstrb = &{1'b0, s_axil_wstrb};

  logic                           wr_v, wr_exec;
  logic [s_axil_addr_width_p-1:0] wr_addr;
  logic [s_axil_data_width_p-1:0] wr_data;

  logic                           ar_fire;
  csr_sel_e                       rd_sel, wr_sel;
  logic [s_axil_data_width_p-1:0] rd_data_n;
  axil_resp_e                     rd_resp_n, wr_resp_n;

  logic underflow_r, overflow_r;
  logic underflow_set, overflow_set, underflow_clr, overflow_clr;

  blackparrot_fpga_host_csr_aw_w_join #(
    .addr_width_p(s_axil_addr_width_p),
    .data_width_p(s_axil_data_width_p)
  ) aw_w_join (
    .clk     (clk),
    .reset   (reset),
    .awaddr  (s_axil_awaddr),
    .awvalid (s_axil_awvalid),
    .awready (s_axil_awready),
    .wdata   (s_axil_wdata),
    .wvalid  (s_axil_wvalid),
    .wready  (s_axil_wready),
    .v_o     (wr_v),
    .addr_o  (wr_addr),
    .data_o  (wr_data),
    .yumi_i  (wr_exec)
  );

  assign s_axil_arready = ~reset & ~s_axil_rvalid;
  assign ar_fire        = s_axil_arvalid & s_axil_arready;
  // A write executes only once the previous B beat has been taken.
  assign wr_exec        = wr_v & ~s_axil_bvalid & ~reset;

  assign rd_sel      = csr_decode(32'(s_axil_araddr & csr_mask_lp));
  assign wr_sel      = csr_decode(32'(wr_addr & csr_mask_lp));
  assign mmio_data_o = wr_data;

  always_comb begin
    rd_data_n              = '0;
    rd_resp_n              = axil_resp_slverr_e;
    mmio_yumi_o            = 1'b0;
    mmio_data_count_yumi_o = 1'b0;
    underflow_set          = 1'b0;
    case (rd_sel)
      csr_sel_req_data_e: begin
        rd_resp_n = axil_resp_okay_e;
        if (mmio_v_i) begin
          rd_data_n   = mmio_data_i;
          mmio_yumi_o = ar_fire;
        end else begin
          underflow_set = ar_fire;
        end
      end
      csr_sel_req_count_e: begin
        rd_resp_n              = axil_resp_okay_e;
        rd_data_n              = mmio_data_count_i;
        mmio_data_count_yumi_o = ar_fire & mmio_data_count_v_i;
      end
      csr_sel_status_e: begin
        rd_resp_n                           = axil_resp_okay_e;
        rd_data_n[status_req_v_bit_gp]      = mmio_v_i;
        rd_data_n[status_resp_ready_bit_gp] = mmio_ready_and_i;
        rd_data_n[status_underflow_bit_gp]  = underflow_r;
        rd_data_n[status_overflow_bit_gp]   = overflow_r;
      end
      csr_sel_id_e: begin
        rd_resp_n = axil_resp_okay_e;
        rd_data_n = id_val_p;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_resp_n     = axil_resp_slverr_e;
    mmio_v_o      = 1'b0;
    overflow_set  = 1'b0;
    underflow_clr = 1'b0;
    overflow_clr  = 1'b0;
    case (wr_sel)
      csr_sel_resp_data_e: begin
        wr_resp_n    = mmio_ready_and_i ? axil_resp_okay_e : axil_resp_slverr_e;
        mmio_v_o     = wr_exec & mmio_ready_and_i;
        overflow_set = wr_exec & ~mmio_ready_and_i;
      end
      csr_sel_status_e: begin
        wr_resp_n     = axil_resp_okay_e;
        underflow_clr = wr_exec & wr_data[status_underflow_bit_gp];
        overflow_clr  = wr_exec & wr_data[status_overflow_bit_gp];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= '0;
    end else if (ar_fire) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= rd_data_n;
      s_axil_rresp  <= rd_resp_n;
    end else if (s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= '0;
    end else if (wr_exec) begin
      s_axil_bvalid <= 1'b1;
      s_axil_bresp  <= wr_resp_n;
    end else if (s_axil_bready) begin
      s_axil_bvalid <= 1'b0;
    end
  end

  // Set beats a same-cycle W1C clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      underflow_r <= (underflow_r & ~underflow_clr) | underflow_set;
      overflow_r  <= (overflow_r & ~overflow_clr) | overflow_set;
    end
  end

endmodule

// File: tb/tb_blackparrot_fpga_host_csr.sv
// Randomized bench for blackparrot_fpga_host_csr against a queue-based model of
// the MMIO FIFOs and the CSR map.
module tb_blackparrot_fpga_host_csr;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_axil_awaddr = '0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = 4'hF;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b0;
  logic [31:0] s_axil_araddr = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;
  logic        mmio_v_i = 1'b0;
  logic [31:0] mmio_data_i = '0;
  logic        mmio_yumi_o;
  logic        mmio_data_count_v_i = 1'b1;
  logic [31:0] mmio_data_count_i = '0;
  logic        mmio_data_count_yumi_o;
  logic        mmio_v_o;
  logic [31:0] mmio_data_o;
  logic        mmio_ready_and_i = 1'b1;

  always #5 clk = ~clk;

  blackparrot_fpga_host_csr dut (
    .clk(clk), .reset(reset),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .mmio_v_i(mmio_v_i), .mmio_data_i(mmio_data_i), .mmio_yumi_o(mmio_yumi_o),
    .mmio_data_count_v_i(mmio_data_count_v_i), .mmio_data_count_i(mmio_data_count_i),
    .mmio_data_count_yumi_o(mmio_data_count_yumi_o),
    .mmio_v_o(mmio_v_o), .mmio_data_o(mmio_data_o), .mmio_ready_and_i(mmio_ready_and_i)
  );

  localparam logic [31:0] ID_VAL = 32'hB9A1_0001;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;

  logic [31:0] req_q[$];
  logic [31:0] push_log[$];
  bit          m_uf = 1'b0, m_of = 1'b0;
  int          obs_pops = 0, obs_cnt_yumi = 0, obs_pushes = 0, push_cycle = 0;
  bit          ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic [31:0] r_dat_seen;
  logic [1:0]  r_resp_seen, b_resp_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    mmio_v_i          = (req_q.size() != 0);
    mmio_data_i       = (req_q.size() != 0) ? req_q[0] : $urandom;
    mmio_data_count_i = req_q.size();
  endtask

  // One clock: observe handshakes mid-cycle, then apply FIFO pops after the edge.
  task automatic tick();
    bit pop_now;
    @(negedge clk);
    ar_hs = s_axil_arvalid && s_axil_arready;
    aw_hs = s_axil_awvalid && s_axil_awready;
    w_hs  = s_axil_wvalid && s_axil_wready;
    r_hs  = s_axil_rvalid && s_axil_rready;
    b_hs  = s_axil_bvalid && s_axil_bready;
    if (r_hs) begin r_dat_seen = s_axil_rdata; r_resp_seen = s_axil_rresp; end
    if (b_hs) b_resp_seen = s_axil_bresp;
    pop_now = mmio_yumi_o;
    if (mmio_yumi_o) begin
      obs_pops++;
      chk("yumi_needs_v", {31'b0, mmio_v_i}, 32'd1);
    end
    if (mmio_data_count_yumi_o) obs_cnt_yumi++;
    if (mmio_v_o) begin
      obs_pushes++;
      push_cycle = cycle;
      push_log.push_back(mmio_data_o);
    end
    @(posedge clk);
    cycle++;
    #1;
    if (pop_now && req_q.size() != 0) void'(req_q.pop_front());
    drive_fifo();
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rdly, input string tag);
    logic [31:0] off, exp_d, first;
    logic [1:0]  exp_r;
    int          exp_pop, exp_cnt, pops0, cnt0, n;
    bit          set_uf;
    off = addr & 32'hFC;
    exp_d = 0; exp_r = 2'b00; exp_pop = 0; exp_cnt = 0; set_uf = 0;
    case (off)
      32'h00: if (req_q.size() != 0) begin exp_d = req_q[0]; exp_pop = 1; end
              else set_uf = 1;
      32'h04: begin exp_d = req_q.size(); exp_cnt = 1; end
      32'h0C: exp_d = {28'b0, m_of, m_uf, mmio_ready_and_i, req_q.size() != 0};
      32'h10: exp_d = ID_VAL;
      default: exp_r = 2'b10;
    endcase
    pops0 = obs_pops; cnt0 = obs_cnt_yumi;
    s_axil_araddr = addr; s_axil_arvalid = 1'b1; s_axil_rready = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!ar_hs && n < 20);
    if (!ar_hs) chk({tag, "_ar_timeout"}, 0, 1);
    s_axil_arvalid = 1'b0; s_axil_araddr = $urandom;
    chk({tag, "_rvalid"}, {31'b0, s_axil_rvalid}, 1);
    first = s_axil_rdata;
    for (int k = 0; k < rdly; k++) begin
      chk({tag, "_arready_blocked"}, {31'b0, s_axil_arready}, 0);
      tick();
      chk({tag, "_rdata_stable"}, s_axil_rdata, first);
    end
    s_axil_rready = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!r_hs && n < 20);
    s_axil_rready = 1'b0;
    if (!r_hs) chk({tag, "_r_timeout"}, 0, 1);
    chk({tag, "_rdata"}, r_dat_seen, exp_d);
    chk({tag, "_rresp"}, {30'b0, r_resp_seen}, {30'b0, exp_r});
    chk({tag, "_pops"}, obs_pops - pops0, exp_pop);
    chk({tag, "_cnt_yumi"}, obs_cnt_yumi - cnt0, exp_cnt);
    if (set_uf) m_uf = 1'b1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input int awd,
                           input int wd, input int bdly, input bit abort_b, input string tag);
    logic [31:0] off;
    logic [1:0]  exp_r;
    int          exp_push, pushes0, n, b_cycle;
    bit          aw_done, w_done;
    off = addr & 32'hFC;
    exp_push = (off == 32'h08 && mmio_ready_and_i) ? 1 : 0;
    exp_r = (off == 32'h0C || exp_push == 1) ? 2'b00 : 2'b10;
    pushes0 = obs_pushes;
    aw_done = 0; w_done = 0; n = 0;
    s_axil_bready = 1'b0;
    while (!(aw_done && w_done) && n < 30) begin
      s_axil_awvalid = !aw_done && n >= awd;
      s_axil_awaddr  = addr;
      s_axil_wvalid  = !w_done && n >= wd;
      s_axil_wdata   = data;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      n++;
    end
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    if (!(aw_done && w_done)) chk({tag, "_aw_w_timeout"}, 0, 1);
    n = 0;
    while (!s_axil_bvalid && n < 20) begin tick(); n++; end
    b_cycle = cycle;
    if (!s_axil_bvalid) chk({tag, "_b_timeout"}, 0, 1);
    if (exp_push == 1) chk({tag, "_b_latency"}, b_cycle - push_cycle, 1);
    if (abort_b) begin
      reset = 1'b1;
      tick();
      chk({tag, "_bvalid_reset"}, {31'b0, s_axil_bvalid}, 0);
      chk({tag, "_pushes"}, obs_pushes - pushes0, exp_push);
      reset = 1'b0;
      m_uf = 1'b0; m_of = 1'b0;
      return;
    end
    for (int k = 0; k < bdly; k++) tick();
    s_axil_bready = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!b_hs && n < 20);
    s_axil_bready = 1'b0;
    if (!b_hs) chk({tag, "_bhs_timeout"}, 0, 1);
    chk({tag, "_bresp"}, {30'b0, b_resp_seen}, {30'b0, exp_r});
    chk({tag, "_pushes"}, obs_pushes - pushes0, exp_push);
    if (exp_push == 1 && push_log.size() != 0) chk({tag, "_push_data"}, push_log[$], data);
    if (off == 32'h08 && !mmio_ready_and_i) m_of = 1'b1;
    if (off == 32'h0C) begin
      if (data[2]) m_uf = 1'b0;
      if (data[3]) m_of = 1'b0;
    end
  endtask

  logic [31:0] rand_bases[8];

  initial begin
    rand_bases[0] = 32'h00; rand_bases[1] = 32'h04; rand_bases[2] = 32'h08; rand_bases[3] = 32'h0C;
    rand_bases[4] = 32'h10; rand_bases[5] = 32'h14; rand_bases[6] = 32'h20; rand_bases[7] = 32'hFC;
    drive_fifo();
    reset = 1'b1;
    tick(); tick();
    chk("rst_arready", {31'b0, s_axil_arready}, 0);
    chk("rst_awready", {31'b0, s_axil_awready}, 0);
    chk("rst_wready",  {31'b0, s_axil_wready}, 0);
    chk("rst_rvalid",  {31'b0, s_axil_rvalid}, 0);
    chk("rst_bvalid",  {31'b0, s_axil_bvalid}, 0);
    chk("rst_rdata",   s_axil_rdata, 0);
    chk("rst_mmio_v",  {31'b0, mmio_v_o}, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", {29'b0, s_axil_arready, s_axil_awready, s_axil_wready}, 32'h7);

    req_q.push_back(32'h8000_1000); req_q.push_back(32'hDEAD_BEEF); drive_fifo();
    axi_read(32'h04, 0, "count");
    axi_read(32'h00, 0, "pop0");
    axi_read(32'h00, 0, "pop1");
    axi_read(32'h00, 0, "pop_empty");
    axi_read(32'h0C, 0, "status_uf");
    axi_write(32'h0C, 32'h4, 0, 0, 0, 0, "w1c_uf");
    axi_read(32'h0C, 0, "status_cleared");
    axi_write(32'h08, 32'h1234_5678, 3, 0, 1, 0, "resp_push");
    mmio_ready_and_i = 1'b0;
    axi_write(32'h08, 32'hCAFE_0000, 0, 0, 0, 0, "resp_ovf");
    axi_read(32'h0C, 0, "status_of");
    mmio_ready_and_i = 1'b1;
    req_q.push_back(32'h5555_AAAA); drive_fifo();
    axi_read(32'h00, 5, "pop_bp");
    axi_read(32'h10, 0, "id");
    axi_read(32'h20, 0, "unmapped");
    axi_read(32'h08, 0, "read_wo");
    axi_write(32'h10, 32'hFFFF_FFFF, 1, 2, 0, 0, "write_ro");
    axi_write(32'h08, 32'h0BAD_F00D, 0, 0, 0, 1, "reset_mid_b");
    axi_read(32'h0C, 0, "status_after_reset");

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = rand_bases[$urandom_range(0, 7)] | ($urandom & 32'hFFFF_FF00) | $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: if (req_q.size() < 8) begin req_q.push_back($urandom); drive_fifo(); end
        1: axi_read(a, $urandom_range(0, 3), "rnd_rd");
        2: axi_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 2), 0, "rnd_wr");
        default: mmio_ready_and_i = $urandom_range(0, 1);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
